// File: rtl/mul_fu_pipe.sv
// rtl/mul_fu_pipe.sv - pipelined unsigned multiply unit (MULQ / UMULH), one operand chunk per stage
module mul_fu_pipe #(
    parameter int XLEN   = 64,
    parameter int STAGES = 4,
    parameter int TAGW   = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_opa,
    input  logic [XLEN-1:0] in_opb,
    input  logic            in_op,
    input  logic [4:0]      in_dest_ar,
    input  logic [TAGW-1:0] in_dest_pr,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_dest_ar,
    output logic [TAGW-1:0] out_dest_pr,
    output logic            busy
);

    localparam int SDIV = (STAGES < 1) ? 1 : STAGES;
    localparam int C    = XLEN / SDIV;
    localparam int AW   = 2 * XLEN;
    localparam int PW   = XLEN + C;
    // Operands only need to travel as far as the stage that consumes the last chunk.
    localparam int OPN  = (STAGES > 1) ? STAGES - 1 : 1;

    if (STAGES < 1 || (XLEN % SDIV) != 0) begin : g_param_check
        $error("mul_fu_pipe: STAGES must be >= 1 and divide XLEN");
    end

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] op_q;
    logic [4:0]        ar_q  [STAGES];
    logic [TAGW-1:0]   pr_q  [STAGES];
    logic [AW-1:0]     acc_q [STAGES];
    logic [XLEN-1:0]   opa_q [OPN];
    logic [XLEN-1:0]   opb_q [OPN];

    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] op_d;
    logic [4:0]        ar_d  [STAGES];
    logic [TAGW-1:0]   pr_d  [STAGES];
    logic [AW-1:0]     acc_d [STAGES];

    logic stall;

    // Chunk k of b times a, aligned to its weight in the double-width product.
    function automatic logic [AW-1:0] partial(input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b,
                                              input int k);
        logic [PW-1:0] p;
        p = PW'(a) * PW'(b[k*C +: C]);
        return AW'(p) << (k * C);
    endfunction

    assign out_valid   = v_q[STAGES-1];
    assign stall       = out_valid & ~out_ready;
    assign in_ready    = ~stall;
    assign busy        = |v_q;
    assign out_result  = op_q[STAGES-1] ? acc_q[STAGES-1][AW-1:XLEN] : acc_q[STAGES-1][XLEN-1:0];
    assign out_dest_ar = ar_q[STAGES-1];
    assign out_dest_pr = pr_q[STAGES-1];

    always_comb begin
        v_d      = '0;
        op_d     = '0;
        v_d[0]   = in_valid & ~flush;
        op_d[0]  = in_op;
        ar_d[0]  = in_dest_ar;
        pr_d[0]  = in_dest_pr;
        acc_d[0] = partial(in_opa, in_opb, 0);
        for (int k = 1; k < STAGES; k++) begin
            v_d[k]   = v_q[k-1];
            op_d[k]  = op_q[k-1];
            ar_d[k]  = ar_q[k-1];
            pr_d[k]  = pr_q[k-1];
            acc_d[k] = acc_q[k-1] + partial(opa_q[k-1], opb_q[k-1], k);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v_q  <= '0;
            op_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ar_q[k]  <= '0;
                pr_q[k]  <= '0;
                acc_q[k] <= '0;
            end
            for (int k = 0; k < OPN; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else begin
            // Flush wins over stall so a blocked result is squashed too.
            if (flush) begin
                v_q <= '0;
            end else if (!stall) begin
                v_q <= v_d;
            end
            if (!stall) begin
                op_q <= op_d;
                for (int k = 0; k < STAGES; k++) begin
                    ar_q[k]  <= ar_d[k];
                    pr_q[k]  <= pr_d[k];
                    acc_q[k] <= acc_d[k];
                end
                opa_q[0] <= in_opa;
                opb_q[0] <= in_opb;
                for (int k = 1; k < OPN; k++) begin
                    opa_q[k] <= opa_q[k-1];
                    opb_q[k] <= opb_q[k-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_fu_pipe.sv
// tb/tb_mul_fu_pipe.sv - scoreboard bench for mul_fu_pipe (64/4 directed, 32/8 and 64/1 random)
module tb_mul_fu_pipe;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, flush;

    logic        m_in_valid, m_in_ready, m_in_op, m_out_valid, m_out_ready, m_busy;
    logic [63:0] m_in_opa, m_in_opb, m_out_result;
    logic [4:0]  m_in_dest_ar, m_out_dest_ar;
    logic [6:0]  m_in_dest_pr, m_out_dest_pr;

    logic        a_in_valid, a_in_ready, a_in_op, a_out_valid, a_out_ready, a_busy;
    logic [31:0] a_in_opa, a_in_opb, a_out_result;
    logic [4:0]  a_in_dest_ar, a_out_dest_ar;
    logic [6:0]  a_in_dest_pr, a_out_dest_pr;

    logic        b_in_valid, b_in_ready, b_in_op, b_out_valid, b_out_ready, b_busy;
    logic [63:0] b_in_opa, b_in_opb, b_out_result;
    logic [4:0]  b_in_dest_ar, b_out_dest_ar;
    logic [6:0]  b_in_dest_pr, b_out_dest_pr;

    mul_fu_pipe #(.XLEN(64), .STAGES(4), .TAGW(7)) u_main (
        .clock(clock), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_opa(m_in_opa), .in_opb(m_in_opb), .in_op(m_in_op), .in_dest_ar(m_in_dest_ar),
        .in_dest_pr(m_in_dest_pr), .flush(flush), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_result(m_out_result), .out_dest_ar(m_out_dest_ar), .out_dest_pr(m_out_dest_pr), .busy(m_busy));

    mul_fu_pipe #(.XLEN(32), .STAGES(8), .TAGW(7)) u_x32 (
        .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_opa(a_in_opa), .in_opb(a_in_opb), .in_op(a_in_op), .in_dest_ar(a_in_dest_ar),
        .in_dest_pr(a_in_dest_pr), .flush(flush), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_result(a_out_result), .out_dest_ar(a_out_dest_ar), .out_dest_pr(a_out_dest_pr), .busy(a_busy));

    mul_fu_pipe #(.XLEN(64), .STAGES(1), .TAGW(7)) u_s1 (
        .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_opa(b_in_opa), .in_opb(b_in_opb), .in_op(b_in_op), .in_dest_ar(b_in_dest_ar),
        .in_dest_pr(b_in_dest_pr), .flush(flush), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_result(b_out_result), .out_dest_ar(b_out_dest_ar), .out_dest_pr(b_out_dest_pr), .busy(b_busy));

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  ar;
        logic [6:0]  pr;
    } exp_t;

    exp_t mq[$];
    exp_t aq[$];
    exp_t bq[$];
    int checks = 0;
    int failures = 0;
    int retired = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic op, input int xlen);
        logic [127:0] p;
        p = {64'b0, a} * {64'b0, b};
        if (xlen == 32) return op ? {32'b0, p[63:32]} : {32'b0, p[31:0]};
        return op ? p[127:64] : p[63:0];
    endfunction

    function automatic exp_t mk(input logic [63:0] r, input logic [4:0] ar, input logic [6:0] pr);
        exp_t e;
        e.res = r;
        e.ar  = ar;
        e.pr  = pr;
        return e;
    endfunction

    // Called at a negedge with inputs set; scores this cycle, returns at the next negedge.
    task automatic m_tick();
        exp_t e;
        #1;
        if (m_out_valid && m_out_ready && !reset) begin
            if (mq.size() == 0) begin
                check("m_spurious_result", 1, 0);
            end else begin
                e = mq.pop_front();
                check("m_result", {m_out_result, m_out_dest_ar, m_out_dest_pr}, e);
                retired++;
            end
        end
        if (m_in_valid && m_in_ready && !flush && !reset)
            mq.push_back(mk(ref_mul(m_in_opa, m_in_opb, m_in_op, 64), m_in_dest_ar, m_in_dest_pr));
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic m_req(input logic [63:0] a, input logic [63:0] b, input logic op,
                         input logic [4:0] ar, input logic [6:0] pr);
        m_in_valid   = 1'b1;
        m_in_opa     = a;
        m_in_opb     = b;
        m_in_op      = op;
        m_in_dest_ar = ar;
        m_in_dest_pr = pr;
    endtask

    task automatic m_drain();
        int n;
        m_in_valid  = 1'b0;
        m_out_ready = 1'b1;
        n = 0;
        while ((mq.size() != 0 || m_busy) && n < 50) begin
            m_tick();
            n++;
        end
        check("m_drain_left", mq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int i, hold, base, na, nb;
        bit seen;
        exp_t e;

        reset = 1'b1; flush = 1'b0;
        m_in_valid = 0; m_in_opa = 0; m_in_opb = 0; m_in_op = 0; m_in_dest_ar = 0; m_in_dest_pr = 0; m_out_ready = 1;
        a_in_valid = 0; a_in_opa = 0; a_in_opb = 0; a_in_op = 0; a_in_dest_ar = 0; a_in_dest_pr = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_opa = 0; b_in_opb = 0; b_in_op = 0; b_in_dest_ar = 0; b_in_dest_pr = 0; b_out_ready = 1;
        @(negedge clock);
        m_tick();
        m_tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid", m_out_valid, 0);
        check("rst_busy", m_busy, 0);
        check("rst_in_ready", m_in_ready, 1);
        check("rst_out_result", m_out_result, 0);
        check("rst_out_dest_pr", m_out_dest_pr, 0);

        // Latency: accepted at edge 0, visible after edge 3.
        m_req(64'd3, 64'd5, 1'b0, 5'd3, 7'h12);
        m_tick();
        m_in_valid = 1'b0;
        check("lat_e0", m_out_valid, 0);
        m_tick();
        check("lat_e1", m_out_valid, 0);
        m_tick();
        check("lat_e2", m_out_valid, 0);
        m_tick();
        check("lat_e3_valid", m_out_valid, 1);
        check("lat_e3_result", m_out_result, 64'd15);
        check("lat_e3_pr", m_out_dest_pr, 7'h12);
        m_drain();

        m_req('1, '1, 1'b1, 5'd5, 7'h21);
        m_tick();
        m_req('1, '1, 1'b0, 5'd6, 7'h22);
        m_tick();
        m_in_valid = 1'b0;
        for (int n = 0; n < 10 && !m_out_valid; n++) m_tick();
        check("umulh_valid", m_out_valid, 1);
        check("umulh_ones", m_out_result, 64'hFFFF_FFFF_FFFF_FFFE);
        m_tick();
        check("mulq_ones_valid", m_out_valid, 1);
        check("mulq_ones", m_out_result, 64'h1);
        m_drain();

        // Six back-to-back requests with a 3-cycle consumer stall after the first result.
        i = 0; hold = 0; seen = 0; base = retired;
        for (int cyc = 0; cyc < 60 && (i < 6 || mq.size() != 0); cyc++) begin
            if (m_out_valid && !seen) begin
                seen = 1;
                hold = 3;
            end
            m_out_ready = (hold == 0);
            if (hold > 0) hold--;
            if (i < 6) m_req({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 5'(i), 7'(8'h40 + i));
            else m_in_valid = 1'b0;
            #1;
            if (!m_out_ready) check("stall_in_ready", m_in_ready, 0);
            if (m_in_valid && m_in_ready) i++;
            m_tick();
        end
        m_in_valid = 1'b0; m_out_ready = 1'b1;
        check("b2b_stall_seen", seen, 1);
        check("b2b_retired", retired - base, 6);
        check("b2b_left", mq.size(), 0);

        // Flush with three in flight plus a fourth presented on the flush cycle.
        for (int k = 0; k < 3; k++) begin
            m_req({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 5'(k), 7'(8'h50 + k));
            m_tick();
        end
        m_req(64'd7, 64'd9, 1'b0, 5'd9, 7'h59);
        flush = 1'b1;
        m_tick();
        flush = 1'b0;
        m_in_valid = 1'b0;
        mq.delete();
        check("flush_out_valid", m_out_valid, 0);
        check("flush_busy", m_busy, 0);
        repeat (8) m_tick();
        check("flush_quiet_busy", m_busy, 0);

        // Reset with two entries in flight and the consumer blocked.
        m_out_ready = 1'b0;
        m_req(64'd11, 64'd13, 1'b0, 5'd1, 7'h61);
        m_tick();
        m_req(64'd17, 64'd19, 1'b1, 5'd2, 7'h62);
        m_tick();
        m_in_valid = 1'b0;
        reset = 1'b1;
        m_tick();
        reset = 1'b0;
        mq.delete();
        #1;
        check("midrst_out_valid", m_out_valid, 0);
        check("midrst_out_result", m_out_result, 0);
        check("midrst_busy", m_busy, 0);
        check("midrst_in_ready", m_in_ready, 1);
        m_out_ready = 1'b1;
        repeat (8) m_tick();
        check("midrst_quiet_busy", m_busy, 0);

        // Random traffic on the 32/8 and 64/1 variants with random back-pressure.
        na = 0; nb = 0;
        for (int cyc = 0; cyc < 4000 && (na < 150 || nb < 150 || aq.size() != 0 || bq.size() != 0); cyc++) begin
            a_out_ready  = ($urandom_range(0, 3) != 0);
            a_in_valid   = (na < 150) && ($urandom_range(0, 3) != 0);
            a_in_opa     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            a_in_opb     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            a_in_op      = 1'($urandom_range(0, 1));
            a_in_dest_ar = 5'($urandom);
            a_in_dest_pr = 7'($urandom);
            b_out_ready  = ($urandom_range(0, 3) != 0);
            b_in_valid   = (nb < 150) && ($urandom_range(0, 3) != 0);
            b_in_opa     = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            b_in_opb     = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
            b_in_op      = 1'($urandom_range(0, 1));
            b_in_dest_ar = 5'($urandom);
            b_in_dest_pr = 7'($urandom);
            #1;
            if (a_out_valid && a_out_ready) begin
                if (aq.size() == 0) check("x32_spurious", 1, 0);
                else begin
                    e = aq.pop_front();
                    check("x32_result", {32'b0, a_out_result, a_out_dest_ar, a_out_dest_pr}, e);
                end
            end
            if (a_in_valid && a_in_ready) begin
                aq.push_back(mk(ref_mul({32'b0, a_in_opa}, {32'b0, a_in_opb}, a_in_op, 32), a_in_dest_ar, a_in_dest_pr));
                na++;
            end
            if (b_out_valid && b_out_ready) begin
                if (bq.size() == 0) check("s1_spurious", 1, 0);
                else begin
                    e = bq.pop_front();
                    check("s1_result", {b_out_result, b_out_dest_ar, b_out_dest_pr}, e);
                end
            end
            if (b_in_valid && b_in_ready) begin
                bq.push_back(mk(ref_mul(b_in_opa, b_in_opb, b_in_op, 64), b_in_dest_ar, b_in_dest_pr));
                nb++;
            end
            @(posedge clock);
            @(negedge clock);
        end
        check("x32_accepted", na, 150);
        check("s1_accepted", nb, 150);
        check("x32_left", aq.size(), 0);
        check("s1_left", bq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_fu_pipe.md
MUL_FU_PIPE -- requirements
Module: mul_fu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 64: operand and result width in bits.
REQ-002 SHALL have parameter STAGES, default 4: pipeline depth; XLEN % STAGES == 0 and STAGES >= 1; other values are an elaboration error.
REQ-003 SHALL have parameter TAGW, default 7: physical destination tag width.
REQ-004 SHALL have port clock, input, 1: clock; all state updates on the rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: request present.
REQ-007 SHALL have port in_ready, output, 1: unit accepts a request this cycle.
REQ-008 SHALL have port in_opa, input, XLEN: multiplicand.
REQ-009 SHALL have port in_opb, input, XLEN: multiplier.
REQ-010 SHALL have port in_op, input, 1: 0 = MULQ (low XLEN bits of product), 1 = UMULH (high XLEN bits of unsigned product).
REQ-011 SHALL have port in_dest_ar, input, 5: architectural destination index, passed through.
REQ-012 SHALL have port in_dest_pr, input, TAGW: physical destination tag, passed through.
REQ-013 SHALL have port flush, input, 1: squash all in-flight work.
REQ-014 SHALL have port out_valid, output, 1: result present.
REQ-015 SHALL have port out_ready, input, 1: consumer (CDB/PRF write) accepts the result.
REQ-016 SHALL have ports out_result (output, XLEN), out_dest_ar (output, 5) and out_dest_pr (output, TAGW): result and its tags.
REQ-017 SHALL have port busy, output, 1: at least one stage holds a valid entry.

Function
REQ-018 SHALL accept a request at a rising edge where in_valid & in_ready & ~flush & ~reset.
REQ-019 SHALL implement STAGES register stages. Stage k (k = 0..STAGES-1) adds in_opb chunk [k*C +: C] * opa << k*C into a 2*XLEN-bit accumulator, where C = XLEN/STAGES.
REQ-020 SHALL carry op, tags and valid through every stage alongside the data.
REQ-021 SHALL, for a request accepted at edge t with no stall, assert out_valid immediately after edge t+STAGES-1 (STAGES edges including the accepting edge).
REQ-022 SHALL drive out_result = acc[XLEN-1:0] when op = 0 and acc[2*XLEN-1:XLEN] when op = 1; all arithmetic is unsigned and modulo 2^(2*XLEN).
REQ-023 SHALL define stall = out_valid & ~out_ready; while stall = 1, every stage register holds its value and in_ready = 0.
REQ-024 SHALL drive in_ready = ~stall combinationally; in_ready SHALL NOT depend on in_valid.
REQ-025 SHALL advance a bubble (valid = 0) through the pipeline when no request is accepted; bubbles do not stall.
REQ-026 SHALL, when out_valid & out_ready at an edge, retire the result; a new result may appear the following cycle, giving throughput of 1 per cycle.
REQ-027 SHALL clear every stage valid bit (including out_valid) on an edge with flush = 1. A request presented in the same cycle is dropped. Flush overrides stall.
REQ-028 SHALL NOT require data or tag registers to be cleared by flush; only valid bits are architecturally visible.
REQ-029 SHALL drive out_result, out_dest_ar and out_dest_pr only from the last stage register, with no combinational path from in_* to out_*.
REQ-030 SHALL drive busy = OR of all stage valid bits.

Reset
REQ-031 SHALL, on an edge with reset = 1, clear all valid bits, giving out_valid = 0, busy = 0 and in_ready = 1 in the next cycle. Reset overrides flush, stall and in_valid.
REQ-032 SHALL reset out_result, out_dest_ar and out_dest_pr to 0.
REQ-033 SHALL, when reset is asserted mid-operation, discard all in-flight requests with no later out_valid for them.

Verification
REQ-034 SHALL be checked for latency, defaults: opa=3, opb=5, op=0, dest_pr=7'h12 accepted at edge 0 -> out_valid=1 after edge 3, out_result=15, out_dest_pr=7'h12.
REQ-035 SHALL be checked for UMULH: opa=opb=64'hFFFF_FFFF_FFFF_FFFF, op=1 -> out_result=64'hFFFF_FFFF_FFFF_FFFE; with op=0 -> 64'h1.
REQ-036 SHALL be checked for back-to-back traffic and stall: 6 requests on consecutive cycles, out_ready=0 for 3 cycles after the first result. Required response: in_ready=0 during the stall, all 6 results emitted in order, none lost or duplicated.
REQ-037 SHALL be checked for flush: 3 requests in flight, flush=1 for one cycle together with a 4th request. Required response: out_valid=0 and busy=0 after that edge, no result emitted for any of the 4.
REQ-038 SHALL be checked for reset mid-operation: reset asserted with 2 entries in flight and out_ready=0. Required response: out_valid=0, out_result=0, busy=0, in_ready=1 the next cycle.
REQ-039 SHALL be checked with random operands at XLEN=32, STAGES=8 and at XLEN=64, STAGES=1, comparing against the reference product for both ops with random out_ready.
